// File: rtl/out_display.sv
// out_display: shows the value of the CPU OUT instruction on a three-digit,
// multiplexed seven-segment display. Each written byte is converted to BCD by
// double-dabble, one shift per clock, and the result is latched into the
// display registers only when the conversion finishes. The scan refreshes the
// digits continuously and does not depend on the converter.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   rst        synchronous, active-high reset
//   out_valid  one-cycle strobe, out_data holds the value to display
//   out_data   unsigned value to display
//   busy       a conversion is in progress
//   overrun    sticky, a pending value was replaced before it was converted
//   seg        segment drive, active-high, seg[0]=a .. seg[6]=g
//   digit_en   one-hot digit enable, bit0=ones, bit1=tens, bit2=hundreds
//
// state   | meaning
// IDLE    | waiting for out_valid
// CONVERT | one double-dabble step per cycle, eight steps in total
// LOAD    | copy BCD result to the display, then chain or go idle
module out_display #(
    parameter int REFRESH_DIV = 16,
    parameter int WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             out_valid,
    input  logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             overrun,
    output logic [6:0]       seg,
    output logic [2:0]       digit_en
);

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [11:0]      bcd;
    logic [11:0]      bcd_adj;
    logic [2:0]       iter_cnt;
    logic [WIDTH-1:0] pend_data;
    logic             pend_valid;
    logic             start_conv;
    logic [WIDTH-1:0] conv_data;
    logic [3:0]       disp_ones, disp_tens, disp_hund;
    logic [3:0]       ones_nxt, tens_nxt, hund_nxt;
    logic [15:0]      refresh_cnt;
    logic             refresh_wrap;
    logic [1:0]       digit_idx, digit_idx_nxt;
    logic [3:0]       digit_val;
    logic             digit_blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_conv = 1'b0;
        case (state)
            IDLE: begin
                if (out_valid) begin
                    state_nxt  = CONVERT;
                    start_conv = 1'b1;
                end
            end
            CONVERT: begin
                if (iter_cnt == 3'd7) state_nxt = LOAD;
            end
            LOAD: begin
                if (out_valid || pend_valid) begin
                    state_nxt  = CONVERT;
                    start_conv = 1'b1;
                end else begin
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // A fresh strobe beats the pending entry when a conversion is chained.
    assign conv_data = (state == LOAD && !out_valid) ? pend_data : out_data;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bcd        <= '0;
            iter_cnt   <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (start_conv) begin
                shift_reg  <= conv_data;
                bcd        <= '0;
                iter_cnt   <= '0;
                pend_valid <= 1'b0;
                // Chaining at LOAD with a strobe drops any pending value.
                if (state == LOAD && out_valid && pend_valid) overrun <= 1'b1;
            end else begin
                if (state == CONVERT) begin
                    bcd       <= {bcd_adj[10:0], shift_reg[WIDTH-1]};
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    iter_cnt  <= iter_cnt + 3'd1;
                end
                if (busy && out_valid) begin
                    pend_data  <= out_data;
                    pend_valid <= 1'b1;
                    if (pend_valid) overrun <= 1'b1;
                end
            end
        end
    end

    // Outputs are built from next-cycle values so seg and digit_en change
    // together in the same register stage.
    assign ones_nxt = (state == LOAD) ? bcd[3:0]  : disp_ones;
    assign tens_nxt = (state == LOAD) ? bcd[7:4]  : disp_tens;
    assign hund_nxt = (state == LOAD) ? bcd[11:8] : disp_hund;

    assign refresh_wrap  = (refresh_cnt == 16'(REFRESH_DIV - 1));
    assign digit_idx_nxt = !refresh_wrap     ? digit_idx :
                           (digit_idx == 2'd2) ? 2'd0    : digit_idx + 2'd1;

    always_comb begin
        digit_val   = ones_nxt;
        digit_blank = 1'b0;
        case (digit_idx_nxt)
            2'd1: begin
                digit_val   = tens_nxt;
                digit_blank = (hund_nxt == 4'd0) && (tens_nxt == 4'd0);
            end
            2'd2: begin
                digit_val   = hund_nxt;
                digit_blank = (hund_nxt == 4'd0);
            end
            default: begin
                digit_val   = ones_nxt;
                digit_blank = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_ones   <= '0;
            disp_tens   <= '0;
            disp_hund   <= '0;
            refresh_cnt <= '0;
            digit_idx   <= '0;
            seg         <= 7'h3F;
            digit_en    <= 3'b001;
        end else begin
            disp_ones   <= ones_nxt;
            disp_tens   <= tens_nxt;
            disp_hund   <= hund_nxt;
            refresh_cnt <= refresh_wrap ? 16'd0 : refresh_cnt + 16'd1;
            digit_idx   <= digit_idx_nxt;
            seg         <= digit_blank ? 7'h00 : seg7(digit_val);
            digit_en    <= 3'b001 << digit_idx_nxt;
        end
    end

endmodule

// File: tb/tb_out_display.sv
module tb_out_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       out_valid = 1'b0;
    logic [7:0] out_data = 8'h00;
    logic       busy, overrun;
    logic [6:0] seg;
    logic [2:0] digit_en;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    out_display #(.REFRESH_DIV(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .overrun   (overrun),
        .seg       (seg),
        .digit_en  (digit_en)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; determines the scan phase.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [6:0] exp_seg7(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Expected scan output for a displayed value h/t/o at the current phase.
    task automatic chk_disp(input string tag, input int h, input int t, input int o);
        int idx;
        int val;
        logic blank;
        idx   = (cyc / 4) % 3;
        val   = (idx == 0) ? o : (idx == 1) ? t : h;
        blank = (idx == 2 && h == 0) || (idx == 1 && h == 0 && t == 0);
        chk({tag, "_en"}, 32'(digit_en), 32'(3'b001 << idx));
        chk({tag, "_seg"}, 32'(seg), 32'(blank ? 7'h00 : exp_seg7(val)));
    endtask

    task automatic scan(input string tag, input int h, input int t, input int o);
        for (int i = 0; i < 12; i++) begin
            chk_disp(tag, h, t, o);
            step();
        end
    endtask

    // Single conversion from IDLE; checks busy is high exactly 9 cycles and
    // the old display holds until the load.
    task automatic convert(input string tag, input logic [7:0] v,
                           input int oh, input int ot, input int oo);
        out_valid = 1'b1;
        out_data  = v;
        step();
        out_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk_disp({tag, "_old"}, oh, ot, oo);
            step();
        end
        chk({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // reset state
        step();
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_en", 32'(digit_en), 32'h1);
        chk("rst_seg", 32'(seg), 32'h3F);

        // 0xFF -> 255
        convert("ff", 8'hFF, 0, 0, 0);
        scan("d255", 2, 5, 5);

        // 0x07 -> 7, leading zeros blanked
        convert("07", 8'h07, 2, 5, 5);
        scan("d7", 0, 0, 7);

        // 0x00 -> only ones shows 0
        convert("00", 8'h00, 0, 0, 7);
        scan("d0", 0, 0, 0);

        // back-to-back writes while busy: pending + overrun
        out_valid = 1'b1; out_data = 8'h10;
        step();                                   // E0
        out_valid = 1'b0;
        step();                                   // E1
        out_valid = 1'b1; out_data = 8'h20;
        step();                                   // E2
        out_valid = 1'b0;
        chk("pend_ovr0", 32'(overrun), 32'd0);
        step();                                   // E3
        out_valid = 1'b1; out_data = 8'h30;
        step();                                   // E4
        out_valid = 1'b0;
        chk("pend_ovr1", 32'(overrun), 32'd1);
        for (int i = 0; i < 5; i++) step();       // E5..E9
        chk("pend_busy9", 32'(busy), 32'd1);
        chk_disp("pend_d16", 0, 1, 6);
        for (int i = 0; i < 8; i++) begin         // E10..E17
            step();
            chk("pend_busy", 32'(busy), 32'd1);
            chk_disp("pend_hold16", 0, 1, 6);
        end
        step();                                   // E18
        chk_disp("pend_d48", 0, 4, 8);
        chk("pend_idle", 32'(busy), 32'd0);
        chk("pend_ovr_sticky", 32'(overrun), 32'd1);

        // strobe in the LOAD cycle chains directly
        do_reset();
        chk("rst_ovr_clr", 32'(overrun), 32'd0);
        out_valid = 1'b1; out_data = 8'h05;
        step();                                   // E0
        out_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();       // E1..E8, now in LOAD
        out_valid = 1'b1; out_data = 8'h64;
        step();                                   // E9
        out_valid = 1'b0;
        chk_disp("load_d5", 0, 0, 5);
        chk("load_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin         // E10..E17
            step();
            chk("load_busy_hold", 32'(busy), 32'd1);
        end
        step();                                   // E18
        chk_disp("load_d100", 1, 0, 0);
        chk("load_idle", 32'(busy), 32'd0);
        chk("load_ovr", 32'(overrun), 32'd0);

        // reset mid-conversion, together with a strobe
        do_reset();
        out_valid = 1'b1; out_data = 8'hC8;
        step();                                   // E0
        out_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();       // E1..E3
        rst = 1'b1; out_valid = 1'b1; out_data = 8'h99;
        step();                                   // E4
        rst = 1'b0; out_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ovr", 32'(overrun), 32'd0);
        scan("abort_d0", 0, 0, 0);
        chk("abort_still_idle", 32'(busy), 32'd0);

        // one-cycle strobe gives exactly one conversion
        convert("2a", 8'h2A, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            chk("single_idle", 32'(busy), 32'd0);
            chk_disp("single_d42", 0, 4, 2);
            step();
        end
        chk("single_ovr", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/out_display.md
OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 Parameter REFRESH_DIV, default 16, clock cycles each digit is enabled before the scan advances (range 2..65535).
REQ-002 Parameter WIDTH, default 8, width of the value written by the CPU OUT instruction; fixed at 8 in this revision.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 out_valid  input  1  one-cycle strobe; the CPU has executed OUT and out_data is valid.
REQ-006 out_data  input  8  unsigned value to display.
REQ-007 busy  output  1  conversion in progress (state != IDLE).
REQ-008 overrun  output  1  sticky flag; a pending value was overwritten before it was converted.
REQ-009 seg  output  7  segment drive, active-high, seg[0]=a ... seg[6]=g.
REQ-010 digit_en  output  3  one-hot digit enable, active-high; bit0=ones, bit1=tens, bit2=hundreds.

Function
REQ-011 FSM states SHALL be IDLE, CONVERT and LOAD, with all transitions registered.
REQ-012 IDLE with out_valid=1: capture out_data into the shift register, clear BCD accumulator (12 bits) and iteration count, go to CONVERT.
REQ-013 CONVERT: per cycle, add 3 to each BCD nibble that is >=5, then shift {bcd,shift_reg} left 1 (double-dabble); after the 8th shift go to LOAD.
REQ-014 LOAD: copy the 3 BCD nibbles into the display registers; go to CONVERT if a new value is available per REQ-016, else go to IDLE.
REQ-015 Latency: display registers SHALL update on the 9th posedge after the capture edge; busy high for exactly 9 cycles per conversion.
REQ-016 out_valid while busy (CONVERT or LOAD): store out_data in a one-entry pending register and set pending_valid; newest value wins.
REQ-017 out_valid while pending_valid=1 and busy SHALL set overrun; overrun clears only on rst.
REQ-018 At the LOAD edge, out_valid in the same cycle SHALL take priority over the pending entry; either source starts the next conversion and clears pending_valid.
REQ-019 An in-flight conversion SHALL never be aborted by out_valid; the display never shows a partially converted value.
REQ-020 Refresh counter counts 0..REFRESH_DIV-1; on wrap, the digit index advances 0->1->2->0 and digit_en follows one-hot.
REQ-021 Segment encoding (g..a hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
REQ-022 Leading-zero blanking: blank hundreds if it is 0; blank tens if hundreds and tens are both 0; never blank ones.
REQ-023 A blanked digit SHALL drive seg=00 with digit_en still asserted.
REQ-024 seg and digit_en SHALL be registered outputs, consistent in the same cycle.
REQ-025 The scan continues independently of busy; the digit values change only at the LOAD edge.

Reset
REQ-026 rst=1 at a posedge: state=IDLE, busy=0, overrun=0, pending_valid=0, display registers=0, refresh counter=0, digit index=0.
REQ-027 In the cycle after reset: digit_en=001, seg=3F (shows "0").
REQ-028 rst SHALL override out_valid in the same cycle; a conversion in progress is discarded without updating the display.

Verification
REQ-029 Reset, out_valid with 0xFF -> busy high 9 cycles, then display 2/5/5; with REFRESH_DIV=4: digit_en 001,010,100 each for 4 cycles, with seg 6D,6D,5B.
REQ-030 out_valid with 0x07 -> ones seg=07; tens and hundreds seg=00; 0x00 -> ones seg=3F only.
REQ-031 out_valid with 0x10 in IDLE, then 0x20 at cycle+2, then 0x30 at cycle+4 -> overrun=1; first display 16; busy stays high; second display 48 at 18 cycles after the first capture.
REQ-032 out_valid with 0x64 in the LOAD cycle of a prior 0x05 conversion, with no pending value -> display 5, then display 100 nine cycles later; busy stays high throughout.
REQ-033 rst asserted 4 cycles into a 0xC8 conversion -> busy=0 next cycle; display stays "0"; overrun=0.
REQ-034 out_valid held high in IDLE for 1 cycle only -> exactly one conversion; pending_valid stays 0.
